// File: rtl/if1_fetch_buffer.sv
// IF1 fetch staging buffer: aligned, credit-flow-controlled circular queue between the I-cache and decode.
// Optional drain FSM for serialising instructions is enabled by defining IF1_BUF_SERIAL_DRAIN_EN.
module if1_fetch_buffer #(
    parameter int unsigned FETCH_W  = 2,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h1c000000,
    parameter logic [31:0] INST_NOP = 32'h03400000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    output logic                 if1_allowin,
    input  logic                 req_fire,
    input  logic                 icache_rready,
    input  logic [31:0]          fetch_pc,
    input  logic [31:0]          fetch_pc_next,
    input  logic                 fetch_taken,
    input  logic [FETCH_W*32-1:0] icache_inst,
    input  logic [31:0]          icache_badv,
    input  logic [6:0]           icache_exception,
    input  logic [1:0]           icache_excp_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_pc_next,
    output logic                 out_taken,
    output logic [FETCH_W*32-1:0] out_inst,
    output logic [FETCH_W-1:0]   out_mask,
    output logic [31:0]          out_badv,
    output logic [6:0]           out_exception,
    output logic [1:0]           out_excp_flag,
    input  logic                 serial_req,
    input  logic                 serial_done,
    output logic                 busy_serial
);

    localparam int unsigned OFF_W = $clog2(FETCH_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IW    = FETCH_W * 32;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W:0]   drop_q, drop_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        pcn_mem   [DEPTH];
    logic               taken_mem [DEPTH];
    logic [IW-1:0]      inst_mem  [DEPTH];
    logic [FETCH_W-1:0] mask_mem  [DEPTH];
    logic [31:0]        badv_mem  [DEPTH];
    logic [6:0]         exc_mem   [DEPTH];
    logic [1:0]         flag_mem  [DEPTH];

    logic [OFF_W-1:0]   off;
    logic [IW-1:0]      inst_shift;
    logic [IW-1:0]      inst_algn;
    logic [FETCH_W-1:0] mask_algn;

    logic resp_live, resp_cnt, full, wr, pop, credit_ok, drop_kill;

    assign off = fetch_pc[OFF_W+1:2];

    // Shift the requested lane down to lane 0; lanes past the line end become NOP.
    always_comb begin
        inst_shift = icache_inst >> {off, 5'b0};
        inst_algn  = '0;
        mask_algn  = '0;
        for (int j = 0; j < FETCH_W; j++) begin
            if ((OFF_W+1)'(j) + {1'b0, off} < (OFF_W+1)'(FETCH_W)) begin
                inst_algn[j*32 +: 32] = inst_shift[j*32 +: 32];
                mask_algn[j]          = 1'b1;
            end else begin
                inst_algn[j*32 +: 32] = INST_NOP;
            end
        end
        if (icache_excp_flag != 2'b00) begin
            mask_algn = FETCH_W'(1);
            for (int j = 1; j < FETCH_W; j++) begin
                inst_algn[j*32 +: 32] = INST_NOP;
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign resp_live = icache_rready && !flush && (drop_q == '0);
    assign wr        = resp_live && (!full || pop);
    assign resp_cnt  = resp_live && (inflight_q != '0);
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W+1)'(DEPTH);
    // A response in the flush cycle retires one outstanding request itself.
    assign drop_kill = icache_rready && ((drop_q != '0) || (inflight_q != '0));

    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (flush) begin
            count_d    = '0;
            inflight_d = CNT_W'(req_fire);
            drop_d     = drop_q + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(drop_kill);
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            count_d    = count_q + CNT_W'(wr) - CNT_W'(pop);
            inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_cnt);
            if (icache_rready && (drop_q != '0)) begin
                drop_d = drop_q - (CNT_W+1)'(1);
            end
            if (wr) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Payload storage carries no reset; empty-buffer outputs come from the mux below.
    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wptr_q]    <= fetch_pc;
            pcn_mem[wptr_q]   <= fetch_pc_next;
            taken_mem[wptr_q] <= fetch_taken;
            inst_mem[wptr_q]  <= inst_algn;
            mask_mem[wptr_q]  <= mask_algn;
            badv_mem[wptr_q]  <= icache_badv;
            exc_mem[wptr_q]   <= icache_exception;
            flag_mem[wptr_q]  <= icache_excp_flag;
        end
    end

    always_comb begin
        out_pc        = PC_RESET;
        out_pc_next   = PC_RESET + 32'd4;
        out_taken     = 1'b0;
        out_inst      = {FETCH_W{INST_NOP}};
        out_mask      = '0;
        out_badv      = '0;
        out_exception = '0;
        out_excp_flag = '0;
        if (out_valid) begin
            out_pc        = pc_mem[rptr_q];
            out_pc_next   = pcn_mem[rptr_q];
            out_taken     = taken_mem[rptr_q];
            out_inst      = inst_mem[rptr_q];
            out_mask      = mask_mem[rptr_q];
            out_badv      = badv_mem[rptr_q];
            out_exception = exc_mem[rptr_q];
            out_excp_flag = flag_mem[rptr_q];
        end
    end

`ifdef IF1_BUF_SERIAL_DRAIN_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DRAIN     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop issuing after a serialising packet, let in-flight responses land, then wait for commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (wr && serial_req)     state_d = S_DRAIN;
            S_DRAIN:     if (inflight_q == '0)     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (serial_done)          state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    assign busy_serial = (state_q != S_IDLE);
    assign if1_allowin = credit_ok && (state_q == S_IDLE);
`else
    logic unused_serial;
    assign unused_serial = serial_req ^ serial_done;
    assign busy_serial   = 1'b0;
    assign if1_allowin   = credit_ok;
`endif

endmodule

// File: tb/tb_if1_fetch_buffer.sv
// Directed bench for if1_fetch_buffer (FETCH_W=2, DEPTH=4); serial-drain checks follow IF1_BUF_SERIAL_DRAIN_EN.
module tb_if1_fetch_buffer;

    localparam logic [31:0] PC_RST = 32'h1c000000;
    localparam logic [31:0] NOP    = 32'h03400000;

    logic        clk = 1'b0;
    logic        rstn, flush, req_fire, icache_rready, fetch_taken;
    logic [31:0] fetch_pc, fetch_pc_next, icache_badv;
    logic [63:0] icache_inst;
    logic [6:0]  icache_exception;
    logic [1:0]  icache_excp_flag;
    logic        out_ready, serial_req, serial_done;
    logic        if1_allowin, out_valid, out_taken, busy_serial;
    logic [31:0] out_pc, out_pc_next, out_badv;
    logic [63:0] out_inst;
    logic [1:0]  out_mask;
    logic [6:0]  out_exception;
    logic [1:0]  out_excp_flag;

    int n_chk = 0;
    int n_err = 0;

    if1_fetch_buffer #(
        .FETCH_W(2), .DEPTH(4), .PC_RESET(PC_RST), .INST_NOP(NOP)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .if1_allowin(if1_allowin),
        .req_fire(req_fire), .icache_rready(icache_rready),
        .fetch_pc(fetch_pc), .fetch_pc_next(fetch_pc_next), .fetch_taken(fetch_taken),
        .icache_inst(icache_inst), .icache_badv(icache_badv),
        .icache_exception(icache_exception), .icache_excp_flag(icache_excp_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_next(out_pc_next), .out_taken(out_taken), .out_inst(out_inst),
        .out_mask(out_mask), .out_badv(out_badv), .out_exception(out_exception),
        .out_excp_flag(out_excp_flag), .serial_req(serial_req),
        .serial_done(serial_done), .busy_serial(busy_serial)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 0; req_fire = 0; icache_rready = 0; fetch_taken = 0;
        fetch_pc = 0; fetch_pc_next = 0; icache_inst = 0; icache_badv = 0;
        icache_exception = 0; icache_excp_flag = 0; out_ready = 0;
        serial_req = 0; serial_done = 0;
    endtask

    function automatic logic [63:0] pat(input logic [31:0] pc);
        return {pc ^ 32'hA5A50001, pc ^ 32'h5A5A0000};
    endfunction

    task automatic resp(input logic [31:0] pc);
        icache_rready = 1; fetch_pc = pc; fetch_pc_next = pc + 32'd8; icache_inst = pat(pc);
    endtask

    // Four requests, each answered the following cycle, downstream stalled.
    task automatic fill4(input logic [31:0] base);
        for (int k = 0; k < 5; k++) begin
            clr();
            if (k < 4) req_fire = 1;
            if (k > 0) resp(base + 32'(8 * (k - 1)));
            tick();
            if (k == 3) check("allowin_after_4th_req", 64'(if1_allowin), 64'd0);
        end
        clr();
        check("allowin_full", 64'(if1_allowin), 64'd0);
    endtask

    task automatic drain(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            clr();
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", 64'(out_pc), 64'(base + 32'(8 * i)));
            check("drain_inst", out_inst, pat(base + 32'(8 * i)));
            check("drain_mask", 64'(out_mask), 64'd3);
            out_ready = 1;
            tick();
        end
        clr();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_empty_pc", 64'(out_pc), 64'(PC_RST));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        clr();
        rstn = 0;
        tick(); tick();
        rstn = 1;
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc", 64'(out_pc), 64'(PC_RST));
        check("rst_pc_next", 64'(out_pc_next), 64'(PC_RST + 32'd4));
        check("rst_inst", out_inst, {NOP, NOP});
        check("rst_mask", 64'(out_mask), 64'd0);
        check("rst_taken", 64'(out_taken), 64'd0);
        check("rst_badv", 64'(out_badv), 64'd0);
        check("rst_exc", 64'(out_exception), 64'd0);
        check("rst_flag", 64'(out_excp_flag), 64'd0);
        check("rst_busy", 64'(busy_serial), 64'd0);
        check("rst_allowin", 64'(if1_allowin), 64'd1);

        // Fill to DEPTH and drain in order.
        fill4(32'h1c000000);
        drain(32'h1c000000, 4);
        check("allowin_after_drain", 64'(if1_allowin), 64'd1);

        // Unaligned fetch: lane 1 moves to lane 0.
        clr(); req_fire = 1; tick();
        clr(); icache_rready = 1; fetch_pc = 32'h1c000004; fetch_pc_next = 32'h1c000040;
        fetch_taken = 1; icache_inst = {32'hBBBB0001, 32'hAAAA0000}; tick();
        clr();
        check("align_inst", out_inst, {NOP, 32'hBBBB0001});
        check("align_mask", 64'(out_mask), 64'd1);
        check("align_pc", 64'(out_pc), 64'h1c000004);
        check("align_pc_next", 64'(out_pc_next), 64'h1c000040);
        check("align_taken", 64'(out_taken), 64'd1);
        out_ready = 1; tick(); clr();

        // Exception packet keeps only lane 0.
        req_fire = 1; tick();
        clr(); icache_rready = 1; fetch_pc = 32'h1c000010; icache_inst = {32'h22222222, 32'h11111111};
        icache_badv = 32'hDEADBEEF; icache_exception = 7'h08; icache_excp_flag = 2'b01; tick();
        clr();
        check("exc_mask", 64'(out_mask), 64'd1);
        check("exc_code", 64'(out_exception), 64'h08);
        check("exc_badv", 64'(out_badv), 64'hDEADBEEF);
        check("exc_flag", 64'(out_excp_flag), 64'd1);
        check("exc_lane0", 64'(out_inst[31:0]), 64'h11111111);
        out_ready = 1; tick(); clr();

        // Stale responses after flush are discarded.
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            clr(); out_ready = 1; req_fire = 1; tick();
        end
        check("stale_allowin_pre", 64'(if1_allowin), 64'd1);
        clr(); out_ready = 1; flush = 1; tick();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_allowin", 64'(if1_allowin), 64'd1);
        for (int i = 0; i < 3; i++) begin
            clr(); out_ready = 1; resp(32'h1c0f0000 + 32'(8 * i)); tick();
            vcnt += int'(out_valid);
        end
        clr(); out_ready = 1; req_fire = 1; tick();
        vcnt += int'(out_valid);
        clr(); out_ready = 1; resp(32'h1c000100); tick();
        check("post_flush_pc", 64'(out_pc), 64'h1c000100);
        vcnt += int'(out_valid);
        for (int i = 0; i < 3; i++) begin
            clr(); out_ready = 1; tick();
            vcnt += int'(out_valid);
        end
        check("post_flush_valid_once", 64'(vcnt), 64'd1);

        // Push and pop together at full, across the pointer wrap.
        fill4(32'h1c001000);
        clr(); out_ready = 1; resp(32'h1c001020); tick();
        clr();
        check("full_pushpop_allowin", 64'(if1_allowin), 64'd0);
        drain(32'h1c001008, 4);

        // Misused response at full without a pop must not be written.
        fill4(32'h1c002000);
        clr(); resp(32'h1c002020); tick();
        drain(32'h1c002000, 4);

        // Reset in the middle of operation.
        clr(); req_fire = 1; tick();
        clr(); req_fire = 1; resp(32'h1c003000); tick();
        clr(); rstn = 0; tick();
        rstn = 1; tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_pc_next", 64'(out_pc_next), 64'(PC_RST + 32'd4));
        check("midrst_allowin", 64'(if1_allowin), 64'd1);
        clr(); req_fire = 1; tick();
        clr(); resp(32'h1c004000); tick();
        clr();
        check("midrst_resp_pc", 64'(out_pc), 64'h1c004000);
        out_ready = 1; tick(); clr();

`ifdef IF1_BUF_SERIAL_DRAIN_EN
        req_fire = 1; tick();
        clr(); req_fire = 1; resp(32'h1c005000); serial_req = 1; tick();
        clr();
        check("ser_busy_drain", 64'(busy_serial), 64'd1);
        check("ser_allowin_drain", 64'(if1_allowin), 64'd0);
        serial_done = 1; tick();
        clr();
        check("ser_done_ignored", 64'(busy_serial), 64'd1);
        resp(32'h1c005008); tick();
        clr(); tick();
        check("ser_wait_busy", 64'(busy_serial), 64'd1);
        check("ser_wait_allowin", 64'(if1_allowin), 64'd0);
        serial_done = 1; tick();
        clr();
        check("ser_idle_busy", 64'(busy_serial), 64'd0);
        check("ser_idle_allowin", 64'(if1_allowin), 64'd1);
        drain(32'h1c005000, 2);
`else
        req_fire = 1; tick();
        clr(); resp(32'h1c005000); serial_req = 1; tick();
        clr();
        check("noser_busy", 64'(busy_serial), 64'd0);
        check("noser_allowin", 64'(if1_allowin), 64'd1);
        drain(32'h1c005000, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
